// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, start-glitch rejection, framing-error strobe.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting around each sample point (needs CLKS_PER_BIT >= 6).
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy,
  output logic       o_Rx_Frame_Err
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decide one cycle late so the three votes straddle the nominal point.
  localparam int START_PT = MID + 1;
`else
  localparam int START_PT = MID;
`endif
  localparam logic [CW-1:0] START_CNT = CW'(START_PT);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

  state_t        state;
  logic          r_Rx_Meta, r_Rx, armed, samp;
  logic [CW-1:0] count;
  logic [2:0]    index;
  logic [7:0]    shift;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_Hist;
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_Hist <= 2'b11;
    else         r_Hist <= {r_Hist[0], r_Rx};
  end
  assign samp = (r_Hist[0] & r_Hist[1]) | (r_Hist[0] & r_Rx) | (r_Hist[1] & r_Rx);
`else
  assign samp = r_Rx;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= IDLE;
      count          <= '0;
      index          <= '0;
      shift          <= '0;
      armed          <= 1'b0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Busy      <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          count     <= '0;
          index     <= '0;
          o_Rx_Busy <= 1'b0;
          if (r_Rx) armed <= 1'b1;
          // The detection cycle counts as the first cycle of the start bit.
          if (armed && !r_Rx) begin
            state     <= START;
            count     <= CW'(1);
            o_Rx_Busy <= 1'b1;
          end
        end
        START: begin
          if (count == START_CNT) begin
            count <= '0;
            if (!samp) begin
              state <= DATA;
            end else begin
              state     <= IDLE;
              o_Rx_Busy <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DATA: begin
          if (count == LAST_CNT) begin
            count        <= '0;
            shift[index] <= samp;
            if (index == 3'd7) begin
              index <= '0;
              state <= STOP;
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        STOP: begin
          if (count == LAST_CNT) begin
            count <= '0;
            state <= CLEANUP;
            if (samp) begin
              o_Rx_Byte <= shift;
              o_Rx_DV   <= 1'b1;
              armed     <= 1'b1;
            end else begin
              // Line held low: refuse new starts until it idles high again.
              o_Rx_Frame_Err <= 1'b1;
              armed          <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        CLEANUP: begin
          state     <= IDLE;
          o_Rx_Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; honours UART_RX_MAJORITY_VOTE_EN for latency and spike test.
module tb_uart_rx;
  localparam int C = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic       dv, busy, fe;
  logic [7:0] rbyte;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_Byte(rbyte), .o_Rx_Busy(busy), .o_Rx_Frame_Err(fe)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, t_start = 0, dv_cyc = 0;
  int dv_count = 0, fe_count = 0, busy_cnt = 0, both_cnt = 0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      if (dv_count == 0) dv_cyc = cyc;
      dv_count++;
      got.push_back(rbyte);
    end
    if (fe) fe_count++;
    if (busy) busy_cnt++;
    if (dv && fe) both_cnt++;
  end

  task automatic clr();
    dv_count = 0; fe_count = 0; busy_cnt = 0; got.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = f[i];
      if (i == 0) t_start = cyc;
      repeat (C - 1) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dv !== 1'b0) $display("FAIL reset_dv got %b want 0", dv); else n_pass++;
    n_checks++; if (rbyte !== 8'h00) $display("FAIL reset_byte got %h want 00", rbyte); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (fe !== 1'b0) $display("FAIL reset_fe got %b want 0", fe); else n_pass++;
    @(negedge clk) rst = 1'b0;
    repeat (2 * C) @(posedge clk);
  endtask

  task automatic test_basic();
    clr();
    send_frame(8'hA5, 1'b1);
    repeat (2 * C) @(posedge clk);
    n_checks++; if (dv_count !== 1) $display("FAIL basic_dv_count got %0d want 1", dv_count); else n_pass++;
    n_checks++; if (rbyte !== 8'hA5) $display("FAIL basic_byte got %h want a5", rbyte); else n_pass++;
    n_checks++; if (dv_cyc - t_start !== 154 + EXTRA) $display("FAIL basic_latency got %0d want %0d", dv_cyc - t_start, 154 + EXTRA); else n_pass++;
    n_checks++; if (busy_cnt !== 152 + EXTRA) $display("FAIL basic_busy_cycles got %0d want %0d", busy_cnt, 152 + EXTRA); else n_pass++;
    n_checks++; if (fe_count !== 0) $display("FAIL basic_fe got %0d want 0", fe_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h55};
    clr();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    repeat (2 * C) @(posedge clk);
    n_checks++; if (dv_count !== 3) $display("FAIL b2b_dv_count got %0d want 3", dv_count); else n_pass++;
    n_checks++; if (fe_count !== 0) $display("FAIL b2b_fe got %0d want 0", fe_count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got.size() <= i) $display("FAIL b2b_byte%0d got none want %h", i, exp[i]);
      else if (got[i] !== exp[i]) $display("FAIL b2b_byte%0d got %h want %h", i, got[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    clr();
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * C) @(posedge clk);
    n_checks++; if (dv_count !== 0) $display("FAIL glitch_dv got %0d want 0", dv_count); else n_pass++;
    n_checks++; if (fe_count !== 0) $display("FAIL glitch_fe got %0d want 0", fe_count); else n_pass++;
    n_checks++; if (busy_cnt !== 7 + EXTRA) $display("FAIL glitch_busy_cycles got %0d want %0d", busy_cnt, 7 + EXTRA); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_end got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_frame_err();
    clr();
    send_frame(8'h3C, 1'b0);
    repeat (40 * C) @(posedge clk);
    n_checks++; if (fe_count !== 1) $display("FAIL ferr_count got %0d want 1", fe_count); else n_pass++;
    n_checks++; if (dv_count !== 0) $display("FAIL ferr_dv got %0d want 0", dv_count); else n_pass++;
    n_checks++; if (rbyte !== 8'h55) $display("FAIL ferr_byte_held got %h want 55", rbyte); else n_pass++;
    n_checks++; if (busy_cnt !== 152 + EXTRA) $display("FAIL ferr_no_restart got %0d want %0d", busy_cnt, 152 + EXTRA); else n_pass++;
    @(posedge clk); #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    clr();
    send_frame(8'h81, 1'b1);
    repeat (2 * C) @(posedge clk);
    n_checks++; if (dv_count !== 1) $display("FAIL after_ferr_dv got %0d want 1", dv_count); else n_pass++;
    n_checks++; if (rbyte !== 8'h81) $display("FAIL after_ferr_byte got %h want 81", rbyte); else n_pass++;
    n_checks++; if (fe_count !== 0) $display("FAIL after_ferr_fe got %0d want 0", fe_count); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [5:0] f;
    f = {3'b000, 2'b11, 1'b0}; // start, then bits 0..4 of 8'hC3
    clr();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 rx = f[i];
      repeat ((i == 5) ? 8 : C - 1) @(posedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dv !== 1'b0) $display("FAIL midrst_dv got %b want 0", dv); else n_pass++;
    n_checks++; if (rbyte !== 8'h00) $display("FAIL midrst_byte got %h want 00", rbyte); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (fe !== 1'b0) $display("FAIL midrst_fe got %b want 0", fe); else n_pass++;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (12 * C) @(posedge clk);
    n_checks++; if (dv_count !== 0) $display("FAIL midrst_no_strobe got %0d want 0", dv_count); else n_pass++;
    clr();
    send_frame(8'h5A, 1'b1);
    repeat (2 * C) @(posedge clk);
    n_checks++; if (dv_count !== 1) $display("FAIL post_rst_dv got %0d want 1", dv_count); else n_pass++;
    n_checks++; if (rbyte !== 8'h5A) $display("FAIL post_rst_byte got %h want 5a", rbyte); else n_pass++;
  endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
  task automatic test_majority();
    logic [9:0] f;
    f = {1'b1, 8'h96, 1'b0};
    clr();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = f[i];
      if (i == 0) t_start = cyc;
      repeat (7) @(posedge clk);
      #1 rx = ~f[i];
      @(posedge clk); #1 rx = f[i];
      repeat (C - 9) @(posedge clk);
    end
    repeat (2 * C) @(posedge clk);
    n_checks++; if (dv_count !== 1) $display("FAIL maj_dv got %0d want 1", dv_count); else n_pass++;
    n_checks++; if (rbyte !== 8'h96) $display("FAIL maj_byte got %h want 96", rbyte); else n_pass++;
    n_checks++; if (dv_cyc - t_start !== 155) $display("FAIL maj_latency got %0d want 155", dv_cyc - t_start); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_majority();
`endif
    n_checks++; if (both_cnt !== 0) $display("FAIL dv_fe_exclusive got %0d want 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver: 8N1 framing, LSB first, idle-high line.
- Sits on the far end of the transmitter's serial line; also used as the ingress stage feeding the byte-processing FSM.
- Recovers bytes by mid-bit sampling, rejects start-bit glitches and flags framing errors.
- Emits one-cycle valid strobes with the received byte.

Parameters:
- CLKS_PER_BIT, 87, i_Clock cycles per bit period. Legal values are >= 4; counter width is $clog2(CLKS_PER_BIT).

Ports:
- i_Clock  in  1  system clock, all logic on posedge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial input, idle high.
- o_Rx_DV  out  1  one-cycle strobe: o_Rx_Byte holds a new valid byte.
- o_Rx_Byte  out  8  last correctly framed byte; holds until the next valid byte.
- o_Rx_Busy  out  1  high from start-bit detection until return to IDLE.
- o_Rx_Frame_Err  out  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (async, i_Reset=1), applied at any time including mid-frame:
  - state=IDLE; counters=0; shift register=0.
  - Synchronizer flops=1.
  - o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Busy=0, o_Rx_Frame_Err=0.
  - Any frame in progress is dropped with no strobe.
- Input sync: i_Rx_Serial passes through 2 flops; all decisions use the second flop (r_Rx). Latency is 2 cycles.
- Sample point: MID = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - Clock count=0, bit index=0, o_Rx_Busy=0.
  - Requires armed=1 (r_Rx seen high since the last frame).
  - r_Rx=0 while armed -> START, o_Rx_Busy=1 on the next edge.
- START:
  - Count up to MID, then sample.
  - r_Rx=0 -> DATA, count=0.
  - r_Rx=1 -> glitch: IDLE, no strobe, o_Rx_Busy drops.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample r_Rx into bit[index], LSB first, and clear the count.
  - index<7 -> index+1. index==7 -> STOP, index=0.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - r_Rx=1: o_Rx_Byte<=shift register, o_Rx_DV=1 for exactly one cycle, armed=1.
  - r_Rx=0: o_Rx_Frame_Err=1 for one cycle, o_Rx_Byte unchanged, armed=0 (break/line-low case: no new start is accepted until r_Rx returns high).
  - Either way -> CLEANUP.
- CLEANUP: one cycle, strobes deassert -> IDLE.
- Latency: o_Rx_DV rises MID + 9*CLKS_PER_BIT + 1 cycles after r_Rx first goes low; add 2 cycles relative to the i_Rx_Serial edge.
- Back-to-back frames:
  - A start bit following the stop bit with zero idle time is caught. Stop sampling happens mid-stop, leaving about CLKS_PER_BIT/2 cycles of margin.
  - The falling edge is detected by level in IDLE, so no edge is missed.
- Only one of o_Rx_DV and o_Rx_Frame_Err is ever high in a cycle. Neither is high outside the STOP->CLEANUP transition edge.
- No backpressure: the consumer must take o_Rx_Byte on the o_Rx_DV cycle. The byte also stays stable until the next DV.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each sample decision (start check, data bits, stop bit) uses a 2-of-3 majority of r_Rx at counts MID-1, MID, MID+1 (start) or CLKS_PER_BIT-2, CLKS_PER_BIT-1, and the first cycle of the next count window. Implement this as 3 samples captured at sample-1, sample, sample+1 relative to the nominal point.
  - The decision is taken one cycle later than nominal; all latencies grow by exactly 1 cycle.
  - Requires CLKS_PER_BIT >= 6.
- Undefined: single sample at the nominal point, as above.

Test Plan:
- CLKS_PER_BIT=16: send 8'hA5 with valid stop -> exactly one o_Rx_DV pulse, o_Rx_Byte=8'hA5, latency 7+144+1+2=154 cycles from the i_Rx_Serial falling edge; o_Rx_Busy high throughout.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three DV pulses, bytes in order, no frame error.
- Low glitch of 3 cycles on the idle line -> returns to IDLE, no DV, no Frame_Err, o_Rx_Busy pulses then clears.
- 8'h3C sent with stop bit forced low and line held low for 40 more bit times -> one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its previous value, no further frames until the line is high. A subsequent 8'h81 is then received correctly.
- Assert i_Reset during data bit 4 of 8'hC3 -> outputs immediately 0/8'h00, no strobe. The next full 8'h5A frame is received correctly.
- With UART_RX_MAJORITY_VOTE_EN: 8'h96 with a 1-cycle inverted spike at each nominal sample point -> o_Rx_Byte=8'h96, DV latency +1 cycle versus the macro-off run.
